// File: rtl/lc3b_regfile_wb.sv
// LC-3b write-back stage: eight-entry register file with DRMUX steering,
// N/Z/P condition codes and a registered no-destination write error pulse.
module lc3b_regfile_wb #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             ld_reg,
    input  logic             ld_cc,
    input  logic [1:0]       dr_sel,
    input  logic [2:0]       ir_dr,
    input  logic [2:0]       sr1,
    input  logic [2:0]       sr2,
    output logic [WIDTH-1:0] sr1_out,
    output logic [WIDTH-1:0] sr2_out,
    output logic             n,
    output logic             z,
    output logic             p,
    output logic             wr_err
);

    logic [WIDTH-1:0] r_regs [NREG];
    logic             r_n;
    logic             r_z;
    logic             r_p;
    logic             r_wr_err;

    logic [2:0]       w_dest_idx;
    logic             w_dest_vld;
    logic [NREG-1:0]  w_we;
    logic [2:0]       w_cc;

    // {n, z, p} classification of a bus value; exactly one bit is set.
    function automatic logic [2:0] cc_of(input logic [WIDTH-1:0] v);
        logic neg;
        logic zero;
        neg  = v[WIDTH-1];
        zero = (v == '0);
        return {neg, zero, !neg && !zero};
    endfunction

    always_comb begin
        w_dest_idx = ir_dr;
        w_dest_vld = 1'b1;
        case (dr_sel)
            2'b00: w_dest_idx = ir_dr;
            2'b01: w_dest_idx = 3'd7;
            2'b10: w_dest_idx = 3'd6;
            2'b11: w_dest_vld = 1'b0;
        endcase
    end

    always_comb begin
        w_we = '0;
        if (ld_reg && w_dest_vld) begin
            w_we[w_dest_idx] = 1'b1;
        end
    end

    assign w_cc = cc_of(bus_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_we[i]) begin
                    r_regs[i] <= bus_in;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n      <= 1'b0;
            r_z      <= 1'b1;
            r_p      <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            if (ld_cc) begin
                {r_n, r_z, r_p} <= w_cc;
            end
            r_wr_err <= ld_reg && !w_dest_vld;
        end
    end

    // Read ports see only committed state; no bypass from bus_in.
    assign sr1_out = r_regs[sr1];
    assign sr2_out = r_regs[sr2];
    assign n       = r_n;
    assign z       = r_z;
    assign p       = r_p;
    assign wr_err  = r_wr_err;

endmodule

// File: tb/tb_lc3b_regfile_wb.sv
// Self-checking bench for lc3b_regfile_wb: expected values are queued when
// stimulus is applied and popped when the corresponding output is sampled.
module tb_lc3b_regfile_wb;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] bus_in = '0;
    logic             ld_reg = 1'b0;
    logic             ld_cc = 1'b0;
    logic [1:0]       dr_sel = 2'b00;
    logic [2:0]       ir_dr = 3'd0;
    logic [2:0]       sr1 = 3'd0;
    logic [2:0]       sr2 = 3'd0;
    logic [WIDTH-1:0] sr1_out;
    logic [WIDTH-1:0] sr2_out;
    logic             n;
    logic             z;
    logic             p;
    logic             wr_err;

    logic [WIDTH-1:0] sb_q [$];
    logic [WIDTH-1:0] exp_v;
    int               n_checks = 0;
    int               n_pass = 0;

    lc3b_regfile_wb #(.WIDTH(WIDTH), .NREG(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus_in  (bus_in),
        .ld_reg  (ld_reg),
        .ld_cc   (ld_cc),
        .dr_sel  (dr_sel),
        .ir_dr   (ir_dr),
        .sr1     (sr1),
        .sr2     (sr2),
        .sr1_out (sr1_out),
        .sr2_out (sr2_out),
        .n       (n),
        .z       (z),
        .p       (p),
        .wr_err  (wr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] post [8];
        // Power-on state while rst_n is held low.
        #2;
        for (int i = 0; i < 8; i++) sb_q.push_back(16'h0000);
        sb_q.push_back(16'(3'b010));
        sb_q.push_back(16'h0000);
        for (int i = 0; i < 8; i++) begin
            sr1 = 3'(i);
            #1;
            exp_v = sb_q.pop_front();
            n_checks++;
            if (sr1_out !== exp_v) $display("FAIL reset_r%0d got %h want %h", i, sr1_out, exp_v);
            else n_pass++;
        end
        exp_v = sb_q.pop_front();
        n_checks++;
        if ({n, z, p} !== exp_v[2:0]) $display("FAIL reset_nzp got %b want %b", {n, z, p}, exp_v[2:0]);
        else n_pass++;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (wr_err !== exp_v[0]) $display("FAIL reset_wr_err got %b want %b", wr_err, exp_v[0]);
        else n_pass++;

        tick();
        rst_n = 1'b1;
        tick();

        // Write R4 = 1234, confirm it landed, then reset mid-cycle during a write.
        ld_reg = 1'b1; dr_sel = 2'b00; ir_dr = 3'd4; bus_in = 16'h1234; sr1 = 3'd4;
        sb_q.push_back(16'h1234);
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (sr1_out !== exp_v) $display("FAIL reset_prewrite got %h want %h", sr1_out, exp_v);
        else n_pass++;

        ld_cc = 1'b1; bus_in = 16'h8000;
        tick();
        ld_cc = 1'b0;
        bus_in = 16'h1234;
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.push_back(16'h0000);
        exp_v = sb_q.pop_front();
        n_checks++;
        if (sr1_out !== exp_v) $display("FAIL reset_async_r4 got %h want %h", sr1_out, exp_v);
        else n_pass++;
        sb_q.push_back(16'(3'b010));
        exp_v = sb_q.pop_front();
        n_checks++;
        if ({n, z, p} !== exp_v[2:0]) $display("FAIL reset_async_nzp got %b want %b", {n, z, p}, exp_v[2:0]);
        else n_pass++;

        // Hold reset across an edge with the write still requested.
        tick();
        rst_n = 1'b1;
        ld_reg = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) post[i] = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(post[i]);
            sr1 = 3'(i);
            #1;
            exp_v = sb_q.pop_front();
            n_checks++;
            if (sr1_out !== exp_v) $display("FAIL reset_post_r%0d got %h want %h", i, sr1_out, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_steering();
        logic [WIDTH-1:0] tbl [8];
        tbl = '{16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 16'h3000, 16'h0042};
        ld_reg = 1'b1; dr_sel = 2'b00; ir_dr = 3'd3; bus_in = 16'hBEEF; sr1 = 3'd3;
        sb_q.push_back(16'h0000);
        #1;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (sr1_out !== exp_v) $display("FAIL steer_nobypass got %h want %h", sr1_out, exp_v);
        else n_pass++;
        tick();
        dr_sel = 2'b01; ir_dr = 3'd0; bus_in = 16'h0042;
        tick();
        dr_sel = 2'b10; bus_in = 16'h3000;
        tick();
        ld_reg = 1'b0; dr_sel = 2'b00;
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(tbl[i]);
            sr2 = 3'(i);
            #1;
            exp_v = sb_q.pop_front();
            n_checks++;
            if (sr2_out !== exp_v) $display("FAIL steer_r%0d got %h want %h", i, sr2_out, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_cc();
        logic [WIDTH-1:0] vals [4];
        logic [2:0]       flg  [4];
        logic             ld   [4];
        vals = '{16'h8000, 16'h0000, 16'h7FFF, 16'h8000};
        flg  = '{3'b100, 3'b010, 3'b001, 3'b001};
        ld   = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            ld_cc = ld[i]; bus_in = vals[i];
            sb_q.push_back(16'(flg[i]));
            tick();
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({n, z, p} !== exp_v[2:0]) $display("FAIL cc_step%0d got %b want %b", i, {n, z, p}, exp_v[2:0]);
            else n_pass++;
        end
        ld_cc = 1'b0;
    endtask

    task automatic test_no_dest();
        logic [WIDTH-1:0] tbl [8];
        tbl = '{16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 16'h3000, 16'h0042};
        ld_reg = 1'b1; ld_cc = 1'b1; dr_sel = 2'b11; ir_dr = 3'd0; bus_in = 16'hFFFF;
        sb_q.push_back(16'(3'b100));
        sb_q.push_back(16'h0001);
        sb_q.push_back(16'h0000);
        tick();
        ld_reg = 1'b0; ld_cc = 1'b0; dr_sel = 2'b00;
        exp_v = sb_q.pop_front();
        n_checks++;
        if ({n, z, p} !== exp_v[2:0]) $display("FAIL nodest_nzp got %b want %b", {n, z, p}, exp_v[2:0]);
        else n_pass++;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (wr_err !== exp_v[0]) $display("FAIL nodest_err_set got %b want %b", wr_err, exp_v[0]);
        else n_pass++;
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (wr_err !== exp_v[0]) $display("FAIL nodest_err_clear got %b want %b", wr_err, exp_v[0]);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(tbl[i]);
            sr1 = 3'(i);
            #1;
            exp_v = sb_q.pop_front();
            n_checks++;
            if (sr1_out !== exp_v) $display("FAIL nodest_r%0d got %h want %h", i, sr1_out, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_dual_read();
        // R2 write coincides with a CC load from the same bus value.
        ld_reg = 1'b1; ld_cc = 1'b1; dr_sel = 2'b00; ir_dr = 3'd2; bus_in = 16'hAAAA;
        sb_q.push_back(16'(3'b100));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if ({n, z, p} !== exp_v[2:0]) $display("FAIL dual_simul_nzp got %b want %b", {n, z, p}, exp_v[2:0]);
        else n_pass++;
        ld_cc = 1'b0; ir_dr = 3'd5; bus_in = 16'h5555;
        tick();
        ld_reg = 1'b0;
        sr1 = 3'd2; sr2 = 3'd5;
        sb_q.push_back(16'hAAAA);
        sb_q.push_back(16'h5555);
        #1;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (sr1_out !== exp_v) $display("FAIL dual_sr1 got %h want %h", sr1_out, exp_v);
        else n_pass++;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (sr2_out !== exp_v) $display("FAIL dual_sr2 got %h want %h", sr2_out, exp_v);
        else n_pass++;
        sr1 = 3'd5;
        sb_q.push_back(16'h5555);
        sb_q.push_back(16'h5555);
        #1;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (sr1_out !== exp_v) $display("FAIL dual_same_sr1 got %h want %h", sr1_out, exp_v);
        else n_pass++;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (sr2_out !== exp_v) $display("FAIL dual_same_sr2 got %h want %h", sr2_out, exp_v);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        sr1 = 3'd1;
        ld_reg = 1'b1; dr_sel = 2'b00; ir_dr = 3'd1; bus_in = 16'h0001;
        sb_q.push_back(16'h0000);
        sb_q.push_back(16'h0001);
        sb_q.push_back(16'h0002);
        #1;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (sr1_out !== exp_v) $display("FAIL b2b_c0 got %h want %h", sr1_out, exp_v);
        else n_pass++;
        tick();
        bus_in = 16'h0002;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (sr1_out !== exp_v) $display("FAIL b2b_c1 got %h want %h", sr1_out, exp_v);
        else n_pass++;
        tick();
        ld_reg = 1'b0;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (sr1_out !== exp_v) $display("FAIL b2b_c2 got %h want %h", sr1_out, exp_v);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_steering();
        test_cc();
        test_no_dest();
        test_dual_read();
        test_back_to_back();
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain got %0d want 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
